// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR vote monitor: health states, replica indices, majority.
package tmr_pkg;

  typedef enum logic [1:0] {
    HS_OK      = 2'd0,
    HS_SUSPECT = 2'd1,
    HS_FAILED  = 2'd2
  } health_e;

  localparam int unsigned REP_A = 0;
  localparam int unsigned REP_B = 1;
  localparam int unsigned REP_C = 2;

  // Widest bus maj3 handles; callers cast in and out.
  localparam int unsigned MAJ_W = 32;

  function automatic logic [MAJ_W-1:0] maj3(input logic [MAJ_W-1:0] a,
                                            input logic [MAJ_W-1:0] b,
                                            input logic [MAJ_W-1:0] c);
    return (a & b) | (b & c) | (c & a);
  endfunction

endpackage

// File: rtl/tmr_vote_monitor_if.sv
// Replica-sample input handshake and voted-result output handshake of the TMR vote monitor.
interface tmr_vote_monitor_if #(
  parameter int unsigned WIDTH = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tmr_health_fsm.sv
// Per-replica health tracker: OK/SUSPECT/FAILED state, consecutive-mismatch run and saturating error count.
module tmr_health_fsm
  import tmr_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             mis,
  input  logic             clr,
  output logic             fail,
  output logic             fail_nxt_c,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned RUN_W = 8;
  localparam logic [1:0] ST_OK      = HS_OK;
  localparam logic [1:0] ST_SUSPECT = HS_SUSPECT;
  localparam logic [1:0] ST_FAILED  = HS_FAILED;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_d;
  logic [RUN_W:0]   run_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OK;
      run_q   <= '0;
      err_cnt <= '0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_cnt <= cnt_d;
      fail    <= fail_nxt_c;
    end
  end

  // Clear wins over a same-cycle accept; FAILED only leaves through clear.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = err_cnt;
    run_inc = (RUN_W+1)'(run_q) + (RUN_W+1)'(1);
    if (clr) begin
      state_d = ST_OK;
      run_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (mis && (err_cnt != CNT_MAX)) cnt_d = err_cnt + CNT_W'(1);
      case (state_q)
        ST_OK, ST_SUSPECT: begin
          if (mis) begin
            run_d   = run_inc[RUN_W-1:0];
            state_d = (run_inc >= (RUN_W+1)'(FAIL_THRESH)) ? ST_FAILED : ST_SUSPECT;
          end else begin
            run_d   = '0;
            state_d = ST_OK;
          end
        end
        default: ;
      endcase
    end
    fail_nxt_c = (state_d == ST_FAILED);
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Registered TMR voter with per-replica health tracking and degraded two-copy voting.
// Optional first-mismatch capture log enabled by defining TMR_ERR_LOG_EN.
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  tmr_vote_monitor_if.slave bus,
  output logic [2:0]       mis_abc,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic [2:0]       fail_abc,
  output logic             dual_mis,
  output logic             fatal
`ifdef TMR_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic [WIDTH-1:0] log_a,
  output logic [WIDTH-1:0] log_b,
  output logic [WIDTH-1:0] log_c,
  output logic [15:0]      log_idx
`endif
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             accept_c;
  logic [WIDTH-1:0] vote_c;
  logic             dual_c;
  logic [2:0]       mis_c;
  logic [2:0]       fail_nxt_c;
  logic [CNT_W-1:0] err_cnt [3];

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign accept_c      = bus.in_valid && bus.in_ready;

  // Degraded vote with one FAILED copy: agreeing bits equal H0 anyway, so the result is H0.
  always_comb begin
    vote_c = WIDTH'(maj3(MAJ_W'(bus.in_a), MAJ_W'(bus.in_b), MAJ_W'(bus.in_c)));
    dual_c = 1'b0;
    case (fail_abc)
      3'b001: begin vote_c = bus.in_b; dual_c = |(bus.in_b ^ bus.in_c); end
      3'b010: begin vote_c = bus.in_a; dual_c = |(bus.in_a ^ bus.in_c); end
      3'b100: begin vote_c = bus.in_a; dual_c = |(bus.in_a ^ bus.in_b); end
      3'b011: vote_c = bus.in_c;
      3'b101: vote_c = bus.in_b;
      3'b110, 3'b111: vote_c = bus.in_a;
      default: ;
    endcase
    mis_c = {|(bus.in_c ^ vote_c), |(bus.in_b ^ vote_c), |(bus.in_a ^ vote_c)};
  end

  for (genvar i = 0; i < 3; i++) begin : g_rep
    tmr_health_fsm #(
      .CNT_W       (CNT_W),
      .FAIL_THRESH (FAIL_THRESH)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (accept_c),
      .mis        (mis_c[i]),
      .clr        (clr),
      .fail       (fail_abc[i]),
      .fail_nxt_c (fail_nxt_c[i]),
      .err_cnt    (err_cnt[i])
    );
  end

  assign err_cnt_a = err_cnt[REP_A];
  assign err_cnt_b = err_cnt[REP_B];
  assign err_cnt_c = err_cnt[REP_C];

  // Result register; fatal looks at next-state fails so simultaneous failures flag on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mis_abc     <= '0;
      dual_mis    <= 1'b0;
      fatal       <= 1'b0;
    end else begin
      if (accept_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= vote_c;
        mis_abc     <= mis_c;
        dual_mis    <= dual_c;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (clr) fatal <= 1'b0;
      else if ((fail_nxt_c[0] & fail_nxt_c[1]) | (fail_nxt_c[1] & fail_nxt_c[2]) |
               (fail_nxt_c[0] & fail_nxt_c[2])) fatal <= 1'b1;
    end
  end

`ifdef TMR_ERR_LOG_EN
  logic [15:0] acc_idx_q;

  // First mismatching sample since reset or clear is captured once, with its accept index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx_q <= '0;
      log_valid <= 1'b0;
      log_a     <= '0;
      log_b     <= '0;
      log_c     <= '0;
      log_idx   <= '0;
    end else begin
      if (accept_c) acc_idx_q <= acc_idx_q + 16'd1;
      if (clr) begin
        log_valid <= 1'b0;
        log_a     <= '0;
        log_b     <= '0;
        log_c     <= '0;
        log_idx   <= '0;
      end else if (accept_c && (|mis_c) && !log_valid) begin
        log_valid <= 1'b1;
        log_a     <= bus.in_a;
        log_b     <= bus.in_b;
        log_c     <= bus.in_c;
        log_idx   <= acc_idx_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Randomized bench for tmr_vote_monitor against a behavioural voting/health model.
module tb_tmr_vote_monitor;

  localparam int unsigned WIDTH       = 2;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned FAIL_THRESH = 4;
  localparam int          CMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  tmr_vote_monitor_if #(.WIDTH(WIDTH)) bus ();

  logic [2:0]       mis_abc;
  logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic [2:0]       fail_abc;
  logic             dual_mis;
  logic             fatal;
`ifdef TMR_ERR_LOG_EN
  logic             log_valid;
  logic [WIDTH-1:0] log_a, log_b, log_c;
  logic [15:0]      log_idx;
`endif

  tmr_vote_monitor #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .FAIL_THRESH (FAIL_THRESH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .mis_abc   (mis_abc),
    .err_cnt_a (err_cnt_a),
    .err_cnt_b (err_cnt_b),
    .err_cnt_c (err_cnt_c),
    .fail_abc  (fail_abc),
    .dual_mis  (dual_mis),
    .fatal     (fatal)
`ifdef TMR_ERR_LOG_EN
    ,
    .log_valid (log_valid),
    .log_a     (log_a),
    .log_b     (log_b),
    .log_c     (log_c),
    .log_idx   (log_idx)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit         mv;
  logic [1:0] md;
  bit   [2:0] mmis;
  bit         mdual;
  bit   [2:0] mfail;
  int         mrun [3];
  int         mcnt [3];
  bit         mfatal;
  bit         mlogv;
  logic [1:0] mlog [3];
  int         mlogidx;
  int         macc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    mv = 0; md = '0; mmis = '0; mdual = 0; mfail = '0; mfatal = 0;
    mlogv = 0; mlogidx = 0; macc = 0;
    for (int i = 0; i < 3; i++) begin
      mrun[i] = 0; mcnt[i] = 0; mlog[i] = '0;
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    chk("out_data",  32'(bus.out_data),  32'(md));
    chk("mis_abc",   32'(mis_abc),       32'(mmis));
    chk("dual_mis",  32'(dual_mis),      32'(mdual));
    chk("err_cnt_a", 32'(err_cnt_a),     32'(mcnt[0]));
    chk("err_cnt_b", 32'(err_cnt_b),     32'(mcnt[1]));
    chk("err_cnt_c", 32'(err_cnt_c),     32'(mcnt[2]));
    chk("fail_abc",  32'(fail_abc),      32'(mfail));
    chk("fatal",     32'(fatal),         32'(mfatal));
`ifdef TMR_ERR_LOG_EN
    chk("log_valid", 32'(log_valid),     32'(mlogv));
    chk("log_a",     32'(log_a),         32'(mlog[0]));
    chk("log_b",     32'(log_b),         32'(mlog[1]));
    chk("log_c",     32'(log_c),         32'(mlog[2]));
    chk("log_idx",   32'(log_idx),       32'(mlogidx));
`endif
  endtask

  // One clock: drive, check ready, advance the model, check registered outputs.
  task automatic step(input bit v, input bit rdy, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input bit cl);
    logic [1:0] rp [3];
    logic [1:0] vote;
    bit         dual;
    bit   [2:0] mis;
    int         h [$];
    bit         acc;
    int         ones;
    @(negedge clk);
    bus.in_valid = v; bus.out_ready = rdy;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; clr = cl;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!mv || rdy));
    acc = v && (!mv || rdy);
    rp[0] = a; rp[1] = b; rp[2] = c;
    for (int i = 0; i < 3; i++) if (!mfail[i]) h.push_back(i);
    dual = 0;
    vote = a;
    if (h.size() == 3) begin
      for (int k = 0; k < 2; k++) begin
        ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
        vote[k] = (ones >= 2);
      end
    end else if (h.size() == 2) begin
      vote = rp[h[0]];
      dual = (rp[h[0]] != rp[h[1]]);
    end else if (h.size() == 1) begin
      vote = rp[h[0]];
    end
    for (int i = 0; i < 3; i++) mis[i] = (rp[i] != vote);
    if (acc) begin
      mv = 1; md = vote; mmis = mis; mdual = dual;
    end else if (rdy) begin
      mv = 0;
    end
    if (cl) begin
      mfail = '0; mfatal = 0; mlogv = 0; mlogidx = 0;
      for (int i = 0; i < 3; i++) begin
        mrun[i] = 0; mcnt[i] = 0; mlog[i] = '0;
      end
    end else if (acc) begin
      if (mis != 0 && !mlogv) begin
        mlogv = 1; mlogidx = macc;
        for (int i = 0; i < 3; i++) mlog[i] = rp[i];
      end
      for (int i = 0; i < 3; i++) begin
        if (mis[i]) begin
          if (mcnt[i] < CMAX) mcnt[i]++;
          if (!mfail[i]) begin
            mrun[i]++;
            if (mrun[i] >= FAIL_THRESH) mfail[i] = 1;
          end
        end else if (!mfail[i]) begin
          mrun[i] = 0;
        end
      end
    end
    if (acc) macc = (macc + 1) % 65536;
    if ($countones(mfail) >= 2) mfatal = 1;
    @(posedge clk);
    #1;
    check_outs();
  endtask

  initial begin
    int         f;
    bit         cl0;
    logic [1:0] v;
    logic [1:0] rr [3];
    bus.in_valid = 0; bus.out_ready = 0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    mreset();
    #12 rst_n = 1'b1;
    check_outs();

    // All replicas agree
    step(1, 1, 2'b10, 2'b10, 2'b10, 0);
    // Single upset on A, then recovery
    step(1, 1, 2'b01, 2'b11, 2'b11, 0);
    step(1, 1, 2'b11, 2'b11, 2'b11, 0);
    // Persistent fault on B until FAILED, then degraded vote
    repeat (4) step(1, 1, 2'b10, 2'b01, 2'b10, 0);
    step(1, 1, 2'b10, 2'b00, 2'b11, 0);
    // Back-pressure then release
    repeat (3) step(1, 0, 2'b01, 2'b01, 2'b00, 0);
    repeat (3) step(1, 1, 2'b01, 2'b10, 2'b11, 0);
    // Clear, then A and C fail together; C saturates
    step(1, 1, 2'b00, 2'b00, 2'b00, 1);
    repeat (5) step(1, 1, 2'b01, 2'b00, 2'b10, 0);
    step(1, 1, 2'b11, 2'b01, 2'b10, 0);
    step(1, 1, 2'b00, 2'b11, 2'b00, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 0);

    // Reset while a result is held
    step(1, 0, 2'b11, 2'b11, 2'b11, 0);
    @(negedge clk);
    bus.in_valid = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1 chk("rst_drop", 32'(bus.out_valid), 32'd0);
    mreset();
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Random phases, each with one (or no) persistently faulty replica
    for (int p = 0; p < 12; p++) begin
      f = $urandom_range(0, 3);
      cl0 = 1'($urandom_range(0, 1));
      for (int n = 0; n < 40; n++) begin
        v = 2'($urandom);
        for (int i = 0; i < 3; i++) begin
          rr[i] = v;
          if (i == f && $urandom_range(0, 3) != 0) rr[i] = v ^ 2'($urandom_range(1, 3));
          else if ($urandom_range(0, 15) == 0) rr[i] = v ^ 2'($urandom_range(1, 3));
        end
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rr[0], rr[1], rr[2],
             (n == 0 && cl0) || ($urandom_range(0, 59) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
